// File: rtl/bitstream_gen_array_pkg.sv
// bsg_pkg: shared FSM state type, default sizes and LFSR tap table for the bitstream generator.
package bsg_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int IWID_DEF = 8;
    localparam int LEN = 2 ** IWID_DEF;

    // Maximal-length Fibonacci taps, bit n-1 set for tap n, widths 4..16.
    function automatic logic [15:0] lfsr_taps(input int w);
        case (w)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/bitstream_gen_array_if.sv
// bitstream_gen_array_if: start/data/stall/abort inputs and busy/valid/stream/done outputs.
interface bitstream_gen_array_if #(
    parameter int IDIM = 4,
    parameter int IWID = 8
);
    logic            iStart;
    logic [IWID-1:0] iData [IDIM-1:0];
    logic            iEn;
    logic            iAbort;
    logic            oBusy;
    logic            oValid;
    logic            oData [IDIM-1:0];
    logic            oDone;

    modport master (output iStart, iData, iEn, iAbort, input oBusy, oValid, oData, oDone);
    modport slave  (input iStart, iData, iEn, iAbort, output oBusy, oValid, oData, oDone);
endinterface

// File: rtl/bitstream_gen_array_rng.sv
// bitstream_rng: IWID-bit number source visiting every value once per 2^IWID steps.
// BSG_LFSR_EN selects a de Bruijn LFSR; otherwise a plain up-counter.
module bitstream_rng
    import bsg_pkg::*;
#(
    parameter int IWID = 8,
    parameter logic [IWID-1:0] SEED = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iLoad,
    input  logic            iEn,
    output logic [IWID-1:0] oRand
);
    logic [IWID-1:0] r_src;
    logic [IWID-1:0] w_next;

`ifdef BSG_LFSR_EN
    localparam logic [15:0] TAPS = lfsr_taps(IWID);
    logic w_fb;
    // Flipping feedback when the low bits are zero splices the all-zero state into the cycle.
    assign w_fb   = (^(r_src & TAPS[IWID-1:0])) ^ (r_src[IWID-2:0] == '0);
    assign w_next = {r_src[IWID-2:0], w_fb};
`else
    assign w_next = r_src + 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst || iLoad)
            r_src <= SEED;
        else if (iEn)
            r_src <= w_next;
    end

    assign oRand = r_src;
endmodule

// File: rtl/bitstream_gen_array.sv
// bitstream_gen_array: binary-to-unary converter, lane i emits iData[i] ones over 2^IWID beats.
// Number source ordering is chosen by BSG_LFSR_EN (see bitstream_rng).
module bitstream_gen_array
    import bsg_pkg::*;
#(
    parameter int IDIM = 4,
    parameter int IWID = 8,
    parameter logic [IWID-1:0] SEED = '0
) (
    input logic clk,
    input logic rst,
    bitstream_gen_array_if.slave bus
);
    state_t          r_state;
    logic [IWID-1:0] r_cnt;
    logic [IWID-1:0] r_val [IDIM-1:0];
    logic [IWID-1:0] w_src;
    logic            w_run;
    logic            w_load;
    logic            w_step;

    assign w_run  = (r_state == RUN);
    assign w_load = (r_state == IDLE) && bus.iStart && !bus.iAbort;
    assign w_step = w_run && bus.iEn && !bus.iAbort;

    bitstream_rng #(.IWID(IWID), .SEED(SEED)) u_rng (
        .clk   (clk),
        .rst   (rst),
        .iLoad (w_load),
        .iEn   (w_step),
        .oRand (w_src)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_val   <= '{default: '0};
        end else if (bus.iAbort) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.iStart) begin
                    r_state <= RUN;
                    r_cnt   <= '0;
                    r_val   <= bus.iData;
                end
                RUN: if (bus.iEn) begin
                    r_cnt <= r_cnt + 1'b1;
                    if (&r_cnt)
                        r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.oBusy  = (r_state != IDLE);
    assign bus.oValid = w_run && bus.iEn;
    assign bus.oDone  = (r_state == DONE);

    for (genvar g = 0; g < IDIM; g++) begin : g_lane
        assign bus.oData[g] = w_run && (w_src < r_val[g]);
    end
endmodule

// File: tb/tb_bitstream_gen_array.sv
// tb_bitstream_gen_array: randomized stimulus with a queue scoreboard against a counter-source reference.
module tb_bitstream_gen_array;
    localparam int IDIM = 4;
    localparam int IWID = 8;
    localparam int LEN  = 256;
    localparam int SEED = 0;

    typedef logic [IDIM-1:0][IWID-1:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bitstream_gen_array_if #(.IDIM(IDIM), .IWID(IWID)) bus ();
    bitstream_gen_array #(.IDIM(IDIM), .IWID(IWID), .SEED(8'(SEED))) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [IDIM-1:0] beat_q [$];
    vec_t            done_q [$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [IDIM-1:0] out_bits();
        logic [IDIM-1:0] o;
        for (int i = 0; i < IDIM; i++) o[i] = bus.oData[i];
        return o;
    endfunction

    // Monitor: compares every presented beat and the per-lane totals at oDone.
    initial begin
        int cnt [IDIM];
        int beats;
        bit last;
        logic [IDIM-1:0] o, e;
        vec_t ev;
        beats = 0;
        last = 0;
        for (int i = 0; i < IDIM; i++) cnt[i] = 0;
        forever begin
            @(negedge clk);
            o = out_bits();
            if (!bus.oBusy || bus.oDone) begin
                check("idle_valid", int'(bus.oValid), 0);
                check("idle_data", int'(o), 0);
            end
            if (bus.oDone) begin
                check("done_after_last_beat", int'(last), 1);
                if (done_q.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    ev = done_q.pop_front();
                    check("beat_total", beats, LEN);
                    for (int i = 0; i < IDIM; i++) check($sformatf("lane%0d_ones", i), cnt[i], int'(ev[i]));
                end
            end else if (last) check("done_missing", 0, 1);
            last = 0;
            if (!bus.oBusy) begin
                beats = 0;
                for (int i = 0; i < IDIM; i++) cnt[i] = 0;
            end
            if (bus.oValid) begin
                if (beat_q.size() == 0) check("extra_beat", 1, 0);
                else begin
                    e = beat_q.pop_front();
                    check($sformatf("beat%0d", beats), int'(o), int'(e));
                end
                for (int i = 0; i < IDIM; i++) cnt[i] += int'(o[i]);
                beats++;
                last = (beats == LEN);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input vec_t d);
        for (int i = 0; i < IDIM; i++) bus.iData[i] = d[i];
    endtask

    // Reference: source value at beat k is SEED+k mod LEN; a lane is 1 while source < value.
    task automatic issue(input vec_t d);
        logic [IDIM-1:0] b;
        bus.iStart = 1'b1;
        set_data(d);
        for (int k = 0; k < LEN; k++) begin
            for (int i = 0; i < IDIM; i++) b[i] = ((SEED + k) % LEN) < int'(d[i]);
            beat_q.push_back(b);
        end
        done_q.push_back(d);
        tick();
        bus.iStart = 1'b0;
    endtask

    // mode: 0 iEn high, 1 low every third cycle, 2 random. kind: 0 plain, 1 ignored starts, 2 abort, 3 reset.
    task automatic run(input int mode, input int stop_at, input int kind);
        int beats;
        int c;
        bit en;
        bit in_run;
        beats = 0;
        for (c = 0; c < 4 * LEN; c++) begin
            if (!bus.oBusy) break;
            if (stop_at >= 0 && beats == stop_at) break;
            en = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 3 != 2) : ($urandom_range(0, 3) != 0);
            bus.iEn = en;
            if (kind == 1 && (c == 5 || bus.oDone)) begin
                bus.iStart = 1'b1;
                set_data({IDIM{8'd255}});
            end
            in_run = bus.oBusy && !bus.oDone;
            tick();
            bus.iStart = 1'b0;
            if (in_run && en) beats++;
        end
        if (c == 4 * LEN) check("stream_timeout", c, 0);
        if (kind == 2) begin
            bus.iAbort = 1'b1;
            bus.iStart = 1'b1;
            bus.iEn = 1'b1;
            tick();
            bus.iAbort = 1'b0;
            bus.iStart = 1'b0;
            check("abort_busy", int'(bus.oBusy), 0);
            check("abort_valid", int'(bus.oValid), 0);
            beat_q.delete();
            done_q.delete();
        end else if (kind == 3) begin
            rst = 1'b1;
            bus.iEn = 1'b1;
            tick();
            check("rst_busy", int'(bus.oBusy), 0);
            check("rst_valid", int'(bus.oValid), 0);
            check("rst_data", int'(out_bits()), 0);
            check("rst_done", int'(bus.oDone), 0);
            tick();
            rst = 1'b0;
            beat_q.delete();
            done_q.delete();
        end else begin
            check("idle_after_stream", int'(bus.oBusy), 0);
        end
        bus.iEn = 1'b0;
        tick();
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < IDIM; i++) v[i] = 8'($urandom_range(0, LEN - 1));
        return v;
    endfunction

    initial begin
        bus.iStart = 1'b0;
        bus.iEn = 1'b0;
        bus.iAbort = 1'b0;
        set_data('0);
        repeat (3) tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            bus.iEn = c[0];
            tick();
            check("reset_busy", int'(bus.oBusy), 0);
            check("reset_valid", int'(bus.oValid), 0);
            check("reset_done", int'(bus.oDone), 0);
            check("reset_data", int'(out_bits()), 0);
        end
        issue({8'd255, 8'd128, 8'd1, 8'd0});
        run(0, -1, 0);
        issue({8'd255, 8'd128, 8'd1, 8'd0});
        run(1, -1, 0);
        issue({8'd3, 8'd3, 8'd3, 8'd3});
        run(0, -1, 1);
        repeat (4) begin
            issue(rand_vec());
            run(2, -1, 0);
        end
        issue(rand_vec());
        run(0, 50, 2);
        issue({8'd200, 8'd17, 8'd128, 8'd64});
        run(0, -1, 0);
        issue(rand_vec());
        run(2, 50, 3);
        issue(rand_vec());
        run(1, -1, 0);
        repeat (4) tick();
        check("beat_queue_drained", beat_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
